// File: rtl/game_button_pio_ctrl.sv
// Avalon-MM button PIO for the ping-pong game: synchronizes, debounces and
// edge-captures raw button pins, and raises a level irq on masked edges.
module game_button_pio_ctrl #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;

  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] w1c_c;
  logic [WIDTH-1:0] edge_cap_next_c;
  logic             mask_we_c;
  logic [31:0]      rd_next_c;

  // Upper write-data bits are meaningless when WIDTH < 32.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  // Two-flop synchronizer for the asynchronous button pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= in_port;
      sync_q2 <= sync_q1;
    end
  end

  // Per-bit debouncer: accept a new level only after it has been stable long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync_q2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync_q2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising-edge detect and edge-capture update; a new rise beats a same-cycle clear.
  always_comb begin
    rise_c          = db & ~db_d;
    w1c_c           = '0;
    mask_we_c       = 1'b0;
    if (write && (address == ADDR_EDGE_CAP)) begin
      w1c_c = writedata[WIDTH-1:0];
    end
    if (write && (address == ADDR_IRQ_MASK)) begin
      mask_we_c = 1'b1;
    end
    edge_cap_next_c = (edge_cap & ~w1c_c) | rise_c;
  end

  // Edge-capture, delayed debounced level and interrupt mask registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_d     <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
    end else begin
      db_d     <= db;
      edge_cap <= edge_cap_next_c;
      if (mask_we_c) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  // Read mux from the current address; reserved location reads zero.
  always_comb begin
    rd_next_c = '0;
    case (address)
      ADDR_DATA:     rd_next_c = 32'(db);
      ADDR_IRQ_MASK: rd_next_c = 32'(irq_mask);
      ADDR_EDGE_CAP: rd_next_c = 32'(edge_cap);
      default:       rd_next_c = '0;
    endcase
  end

  // Registered read data, refreshed every cycle (read latency 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next_c;
    end
  end

  // Level interrupt straight from registered state.
  assign irq = |(edge_cap & irq_mask);

endmodule
